// File: rtl/div_pkg.sv
// Shared constants and state encoding for the iterative signed divider.
package div_pkg;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned ITERS = WIDTH;
    localparam int unsigned CNT_W = $clog2(ITERS) + 1;

    typedef enum logic [2:0] {
        StIdle = 3'd0,
        StRun  = 3'd1,
        StSign = 3'd2,
        StDone = 3'd3,
        StZero = 3'd4
    } state_e;

endpackage

// File: rtl/div_if.sv
// Request/response bundle between the control unit (master) and the divider (slave).
interface div_if #(
    parameter int unsigned WIDTH = 32
) ();

    logic             div_start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic [WIDTH-1:0] hi_out;
    logic [WIDTH-1:0] lo_out;
    logic             div_done;
    logic             div_zero;
    logic             busy;

    modport master (
        output div_start, dividend, divisor,
        input  hi_out, lo_out, div_done, div_zero, busy
    );

    modport slave (
        input  div_start, dividend, divisor,
        output hi_out, lo_out, div_done, div_zero, busy
    );

endinterface

// File: rtl/div_step.sv
// One restoring-division iteration on magnitudes: shift in the next dividend bit,
// subtract the divisor if it fits, and emit one quotient bit.
module div_step #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH:0]   rem,
    input  logic [WIDTH-1:0] quo,
    input  logic [WIDTH-1:0] divisor_abs,
    output logic [WIDTH:0]   rem_next,
    output logic [WIDTH-1:0] quo_next
);

    logic [WIDTH+1:0] trial;

    always_comb begin
        // Extra top bit acts as the borrow/sign of the trial subtraction.
        trial = {rem, quo[WIDTH-1]} - {2'b00, divisor_abs};
        if (!trial[WIDTH+1]) begin
            rem_next = trial[WIDTH:0];
            quo_next = {quo[WIDTH-2:0], 1'b1};
        end else begin
            rem_next = {rem[WIDTH-1:0], quo[WIDTH-1]};
            quo_next = {quo[WIDTH-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/div_unit.sv
// Iterative 32-bit signed divider: remainder to hi_out, quotient to lo_out.
// Magnitudes are divided by restoring steps, then signs are applied in SIGN.
module div_unit
    import div_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned ITERS = WIDTH
) (
    input logic  clk,
    input logic  reset,
    div_if.slave bus
);

    localparam int unsigned CntW = $clog2(ITERS) + 1;

    state_e state_q, state_d;

    logic [WIDTH:0]   rem_q;
    logic [WIDTH-1:0] quo_q;
    logic [WIDTH-1:0] dvs_q;
    logic [CntW-1:0]  cnt_q;
    logic             neg_quo_q;
    logic             neg_rem_q;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;

    logic [WIDTH:0]   rem_next;
    logic [WIDTH-1:0] quo_next;

    div_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .rem         (rem_q),
        .quo         (quo_q),
        .divisor_abs (dvs_q),
        .rem_next    (rem_next),
        .quo_next    (quo_next)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (bus.div_start) begin
                    state_d = (bus.divisor == '0) ? StZero : StRun;
                end
            end
            StRun: begin
                if (cnt_q == CntW'(ITERS - 1)) begin
                    state_d = StSign;
                end
            end
            StSign:  state_d = StDone;
            StDone:  state_d = StIdle;
            StZero:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        bus.div_done = (state_q == StDone);
        bus.div_zero = (state_q == StZero);
        bus.busy     = (state_q != StIdle);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            rem_q     <= '0;
            quo_q     <= '0;
            dvs_q     <= '0;
            cnt_q     <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (bus.div_start && (bus.divisor != '0)) begin
                        // Negating the most negative value wraps to itself, which is
                        // exactly its unsigned magnitude.
                        quo_q     <= bus.dividend[WIDTH-1] ? -bus.dividend : bus.dividend;
                        dvs_q     <= bus.divisor[WIDTH-1] ? -bus.divisor : bus.divisor;
                        neg_quo_q <= bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1];
                        neg_rem_q <= bus.dividend[WIDTH-1];
                        rem_q     <= '0;
                        cnt_q     <= '0;
                    end
                end
                StRun: begin
                    rem_q <= rem_next;
                    quo_q <= quo_next;
                    cnt_q <= cnt_q + CntW'(1);
                end
                StSign: begin
                    lo_q <= neg_quo_q ? -quo_q : quo_q;
                    hi_q <= neg_rem_q ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];
                end
                default: ;
            endcase
        end
    end

    assign bus.hi_out = hi_q;
    assign bus.lo_out = lo_q;

endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Iterative 32-bit signed divider for the multicycle CPU datapath; executes DIV.
- Writes remainder to hi_out and quotient to lo_out. These registered results feed the HI/LO write-source 5:1 selector directly downstream.
- The control unit starts it with a one-cycle pulse and waits for div_done or div_zero (divide-by-zero exception path).

Parameters:
- WIDTH, 32, operand and result width (only 32 is verified).
- ITERS, WIDTH, number of restoring iterations (one quotient bit per cycle).

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-low reset (0 = reset, sampled on clk rising edge).
- div_start  input  1  one-cycle request; sampled only in IDLE.
- dividend  input  WIDTH  signed dividend (rs); sampled with div_start.
- divisor  input  WIDTH  signed divisor (rt); sampled with div_start.
- hi_out  output  WIDTH  signed remainder, registered.
- lo_out  output  WIDTH  signed quotient, registered.
- div_done  output  1  one-cycle pulse: hi_out/lo_out hold a new result.
- div_zero  output  1  one-cycle pulse: divisor was 0; no result written.
- busy  output  1  high in every non-IDLE state.

Behaviour:
- Reset (reset=0 at an edge):
  - state=IDLE.
  - hi_out=0, lo_out=0, div_done=0, div_zero=0, busy=0.
  - Internal registers cleared.
  - Reset overrides everything, including mid-operation: no done/zero pulse is emitted for the aborted operation.
- States: IDLE, RUN, SIGN, DONE, ZERO.
- IDLE:
  - div_start=1 and divisor==0 -> ZERO.
  - div_start=1 and divisor!=0 -> RUN. On that edge:
    - latch |dividend| and |divisor| as unsigned WIDTH values;
    - latch sign_q = dividend[MSB] XOR divisor[MSB] and sign_r = dividend[MSB];
    - clear partial remainder (WIDTH+1 bits) and iteration counter.
  - div_start=0 -> stay in IDLE.
- RUN: each cycle performs one restoring step:
  - shift {rem, quo} left by 1, bringing the dividend MSB into rem;
  - trial = rem - |divisor| (WIDTH+1-bit);
  - if trial is non-negative: rem = trial and quotient bit = 1; else quotient bit = 0;
  - counter increments; after ITERS steps -> SIGN.
- SIGN:
  - lo_out <= sign_q ? -quo : quo;
  - hi_out <= sign_r ? -rem : rem;
  - -> DONE.
- DONE: div_done=1 for this cycle only; -> IDLE.
- ZERO: div_zero=1 for this cycle only; hi_out/lo_out unchanged; -> IDLE.
- Latency: div_start sampled in cycle 0.
  - Cycles 1..32 are RUN, cycle 33 is SIGN.
  - div_done=1 in cycle 34, and hi_out/lo_out are valid from cycle 34.
  - Divide-by-zero: div_zero=1 in cycle 1.
- hi_out/lo_out hold their value until the next successful division completes or reset.
- div_start while busy=1 is ignored (no queueing). div_start in the DONE/ZERO cycle is also ignored.
- Operands only matter in the cycle div_start is sampled; later changes have no effect.
- Arithmetic rules:
  - quotient truncates toward zero;
  - remainder takes the dividend's sign; |remainder| < |divisor|.
  - 0x80000000 / 0xFFFFFFFF: lo_out=0x80000000, hi_out=0 (wraps, no exception).
  - |0x80000000| is handled as unsigned 0x80000000.
- div_done and div_zero are never high in the same cycle.

Decomposition:
- Shared package div_pkg:
  - WIDTH constant;
  - state encoding constants (IDLE=0, RUN=1, SIGN=2, DONE=3, ZERO=4; 3-bit);
  - counter width constant ($clog2(ITERS)+1).
- One natural sub-module: div_step, a combinational single restoring iteration.
  - Inputs: rem, quo, divisor_abs.
  - Outputs: next rem, next quo.
  - Instantiated once inside the RUN datapath.

Test Plan:
- 100 / 7 -> div_done in cycle 34, lo_out=14 (0x0000000E), hi_out=2; busy high in cycles 1..33.
- -100 / 7 -> lo_out=0xFFFFFFF2 (-14), hi_out=0xFFFFFFFE (-2). Also 100 / -7 -> lo_out=-14, hi_out=2.
- 0x80000000 / 0xFFFFFFFF -> lo_out=0x80000000, hi_out=0, div_done=1, div_zero never asserted.
- Prior result 14/2 held, then 55 / 0 -> div_zero=1 in cycle 1 only, div_done stays 0, hi_out=2 and lo_out=14 unchanged, busy=0 by cycle 2.
- 7 / 100 -> lo_out=0, hi_out=7. Then during that run, div_start pulsed at cycle 10 with 9/3 -> ignored; result still lo_out=0, hi_out=7 at cycle 34.
- Start 100/7, drive reset=0 at cycle 10 -> next cycle hi_out=lo_out=0, busy=0, no div_done. After release, 9/3 -> lo_out=3, hi_out=0, 34 cycles after its start.
